// File: rtl/seg_scan_pkg.sv
// Shared types, constants and digit helpers for the seven-segment scan controller.
package seg_scan_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_e;

  localparam int NUM_DIGITS = 3;
  localparam int NIB_W      = 4;

  localparam int DIG0_LSB = 0;
  localparam int DIG1_LSB = 4;
  localparam int DIG2_LSB = 8;

  localparam logic [2:0] ENA_OFF = 3'b111;
  localparam logic [NUM_DIGITS-1:0][2:0] ENA_DIG = {3'b011, 3'b101, 3'b110};

  function automatic logic [3:0] digit_nibble(input logic [11:0] data, input logic [1:0] idx);
    case (idx)
      2'd0:    digit_nibble = data[DIG0_LSB +: NIB_W];
      2'd1:    digit_nibble = data[DIG1_LSB +: NIB_W];
      default: digit_nibble = data[DIG2_LSB +: NIB_W];
    endcase
  endfunction

  // Index 3 never occurs in normal operation; keep the display dark if it does.
  function automatic logic [2:0] digit_enable(input logic [2:0] mask, input logic [1:0] idx);
    case (idx)
      2'd0:    digit_enable = mask[0] ? ENA_OFF : ENA_DIG[0];
      2'd1:    digit_enable = mask[1] ? ENA_OFF : ENA_DIG[1];
      2'd2:    digit_enable = mask[2] ? ENA_OFF : ENA_DIG[2];
      default: digit_enable = ENA_OFF;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_scheduler_if.sv
// Client write channel of the scan controller: valid/ready frame handshake.
interface seg_scan_scheduler_if;
  logic        WrValid;
  logic        WrReady;
  logic [11:0] WrData;
  logic [2:0]  WrBlank;

  modport master (output WrValid, output WrData, output WrBlank, input WrReady);
  modport slave  (input WrValid, input WrData, input WrBlank, output WrReady);
endinterface

// File: rtl/seg_scan_scheduler_scan_timer.sv
// Loadable down-counter that parks at zero and flags it; reloaded on every state entry.
module scan_timer #(
  parameter int               CNT_W   = 1,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Load,
  input  logic [CNT_W-1:0] LoadValue,
  output logic             Zero
);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                 count_q <= RST_VAL;
    else if (Load)           count_q <= LoadValue;
    else if (count_q != '0)  count_q <= count_q - CNT_W'(1);
  end

  assign Zero = (count_q == '0);

endmodule

// File: rtl/seg_scan_scheduler.sv
// Three-digit multiplexed display scanner with blanking gaps and frame-aligned double-buffered writes.
module seg_scan_scheduler
  import seg_scan_pkg::*;
#(
  parameter int unsigned DWELL        = 12000000,
  parameter int unsigned BLANK_CYCLES = 1200
) (
  input  logic                       Clk,
  input  logic                       Rst,
  seg_scan_scheduler_if.slave        wr,
  output logic [2:0]                 Enable,
  output logic [3:0]                 BinValue,
  output logic                       FrameDone
);

  // A zero-length gap still needs one cycle to load BinValue ahead of lighting the digit.
  localparam int unsigned BLANK_LEN = (BLANK_CYCLES > 0) ? BLANK_CYCLES : 1;
  localparam int unsigned MAX_LEN   = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
  localparam int          CNT_W     = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_LEN - 1);

  scan_state_e state_q;
  logic [1:0]  idx_q;
  logic [11:0] active_data_q;
  logic [2:0]  active_mask_q;
  logic [11:0] pend_data_q;
  logic [2:0]  pend_mask_q;
  logic        pend_full_q;

  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic             boundary;
  logic             apply;
  logic             wr_accept;
  logic [1:0]       idx_next;
  logic [11:0]      next_data;

  assign cnt_load_val = (state_q == BLANK) ? DWELL_LOAD : BLANK_LOAD;

  scan_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (BLANK_LOAD)
  ) u_timer (
    .Clk       (Clk),
    .Rst       (Rst),
    .Load      (cnt_zero),
    .LoadValue (cnt_load_val),
    .Zero      (cnt_zero)
  );

  // Index 3 is treated like digit2 so a corrupted index still closes the frame and wraps.
  assign boundary  = (state_q == ON) && cnt_zero && (idx_q >= 2'd2);
  assign apply     = boundary && pend_full_q;
  assign wr_accept = wr.WrValid && !pend_full_q;
  assign idx_next  = (idx_q >= 2'd2) ? 2'd0 : idx_q + 2'd1;
  assign next_data = apply ? pend_data_q : active_data_q;

  assign FrameDone  = boundary;
  assign wr.WrReady = !pend_full_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= BLANK;
      idx_q    <= 2'd0;
      Enable   <= ENA_OFF;
      BinValue <= 4'd0;
    end else if (cnt_zero) begin
      if (state_q == BLANK) begin
        state_q <= ON;
        Enable  <= digit_enable(active_mask_q, idx_q);
      end else begin
        state_q  <= BLANK;
        idx_q    <= idx_next;
        Enable   <= ENA_OFF;
        BinValue <= digit_nibble(next_data, idx_next);
      end
    end
  end

  // Pending may only be refilled after the boundary has drained it, so a write landing on the boundary waits a frame.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      active_data_q <= 12'h000;
      active_mask_q <= 3'b111;
      pend_data_q   <= 12'h000;
      pend_mask_q   <= 3'b000;
      pend_full_q   <= 1'b0;
    end else begin
      if (apply) begin
        active_data_q <= pend_data_q;
        active_mask_q <= pend_mask_q;
        pend_full_q   <= 1'b0;
      end else if (wr_accept) begin
        pend_data_q <= wr.WrData;
        pend_mask_q <= wr.WrBlank;
        pend_full_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed self-checking bench for seg_scan_scheduler with DWELL=4, BLANK_CYCLES=2 (18-cycle frames).
module tb_seg_scan_scheduler;

  localparam int FRAME = 18;
  localparam int SLOT  = 6;

  logic       Clk;
  logic       Rst;
  logic [2:0] Enable;
  logic [3:0] BinValue;
  logic       FrameDone;

  seg_scan_scheduler_if wr_if ();

  seg_scan_scheduler #(
    .DWELL        (4),
    .BLANK_CYCLES (2)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .wr        (wr_if),
    .Enable    (Enable),
    .BinValue  (BinValue),
    .FrameDone (FrameDone)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int vectors    = 0;
  int miscompares = 0;

  // Expected display state: phase 0 is the first gap cycle of digit0 in a frame.
  int          phase;
  logic [11:0] exp_data;
  logic [2:0]  exp_mask;
  logic        exp_ready;
  logic [11:0] m_pend_data;
  logic [2:0]  m_pend_mask;
  logic        m_pend_full;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h phase=%0d t=%0t", tag, obs, expv, phase, $time);
    end
  endtask

  function automatic logic [2:0] enc(input int d);
    case (d)
      0:       enc = 3'b110;
      1:       enc = 3'b101;
      default: enc = 3'b011;
    endcase
  endfunction

  task automatic check_outputs();
    int d, q;
    logic [2:0] e_en;
    d    = phase / SLOT;
    q    = phase % SLOT;
    e_en = (q < 2 || exp_mask[d]) ? 3'b111 : enc(d);
    check("Enable",    12'(Enable),    12'(e_en));
    check("BinValue",  12'(BinValue),  12'(exp_data[4*d +: 4]));
    check("FrameDone", 12'(FrameDone), 12'(phase == FRAME - 1));
    check("WrReady",   12'(wr_if.WrReady), 12'(exp_ready));
  endtask

  task automatic model_reset();
    phase       = 0;
    exp_data    = 12'h000;
    exp_mask    = 3'b111;
    m_pend_full = 1'b0;
    exp_ready   = 1'b1;
  endtask

  // Advance one clock; WrValid is held until the bench expects acceptance, then dropped.
  task automatic step();
    logic acc, bnd;
    acc = wr_if.WrValid && exp_ready;
    bnd = (phase == FRAME - 1);
    @(negedge Clk);
    phase = (phase + 1) % FRAME;
    if (bnd && m_pend_full) begin
      exp_data    = m_pend_data;
      exp_mask    = m_pend_mask;
      m_pend_full = 1'b0;
    end
    if (acc) begin
      m_pend_data   = wr_if.WrData;
      m_pend_mask   = wr_if.WrBlank;
      m_pend_full   = 1'b1;
      wr_if.WrValid = 1'b0;
    end
    exp_ready = !m_pend_full;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_phase(input int target);
    for (int i = 0; i < FRAME && phase != target; i++) step();
  endtask

  task automatic offer(input logic [11:0] data, input logic [2:0] mask);
    wr_if.WrData  = data;
    wr_if.WrBlank = mask;
    wr_if.WrValid = 1'b1;
  endtask

  initial begin
    Rst           = 1'b1;
    wr_if.WrValid = 1'b0;
    wr_if.WrData  = 12'h000;
    wr_if.WrBlank = 3'b000;
    model_reset();

    repeat (3) @(negedge Clk);
    check("rst_Enable",    12'(Enable),        12'h007);
    check("rst_BinValue",  12'(BinValue),      12'h000);
    check("rst_FrameDone", 12'(FrameDone),     12'h000);
    check("rst_WrReady",   12'(wr_if.WrReady), 12'h001);
    Rst = 1'b0;
    check_outputs();

    // Two dark frames with no writes.
    run(2 * FRAME);

    // First frame: accepted immediately, shown from the next boundary.
    offer(12'h5B1, 3'b000);
    run(2 * FRAME);

    // Back-to-back writes: the second is held off until the first is applied.
    offer(12'h789, 3'b000);
    step();
    offer(12'h123, 3'b010);
    run(3 * FRAME);

    // Write landing exactly on the FrameDone cycle waits a whole frame.
    run_to_phase(FRAME - 1);
    offer(12'hF0E, 3'b000);
    run(2 * FRAME);

    // Reset during ON(digit1) with a frame pending: everything returns dark immediately.
    offer(12'h456, 3'b000);
    step();
    run_to_phase(9);
    #2 Rst = 1'b1;
    #1;
    check("midrst_Enable",    12'(Enable),        12'h007);
    check("midrst_WrReady",   12'(wr_if.WrReady), 12'h001);
    check("midrst_FrameDone", 12'(FrameDone),     12'h000);
    check("midrst_BinValue",  12'(BinValue),      12'h000);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    model_reset();
    check_outputs();
    run(2 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_scheduler.md
Name: seg_scan_scheduler

Overview:
Scan controller for the 3-digit multiplexed seven-segment display. It time-multiplexes one shared BCD/hex decoder across the digits. It drives the active-low digit enables and the 4-bit value sent to the decoder, and inserts a blanking gap between digits to prevent ghosting. Client writes use a valid/ready handshake and are double-buffered. Each write is applied only at a frame boundary, so a displayed frame never tears.

Parameters:
DWELL, 12000000, clock cycles each digit is lit (legal: >= 1)
BLANK_CYCLES, 1200, clock cycles with all digits off between digits (legal: >= 0; 0 = no gap)

Ports:
Clk  in  1  system clock
Rst  in  1  asynchronous reset, active-high
WrValid  in  1  client offers a new frame
WrReady  out  1  pending buffer empty; write is accepted when WrValid && WrReady
WrData  in  12  digit values; [3:0] digit0, [7:4] digit1, [11:8] digit2
WrBlank  in  3  per-digit blank mask; 1 = digit stays dark
Enable  out  3  active-low digit enables; digit0 = 3'b110, digit1 = 3'b101, digit2 = 3'b011, off = 3'b111
BinValue  out  4  value fed to the shared decoder
FrameDone  out  1  one-cycle pulse when digit2's slot ends

Behaviour:
- Reset values (asynchronous): Enable=3'b111, BinValue=0, FrameDone=0, WrReady=1, digit index=0, active data=0, active mask=3'b111 (dark until the first frame is applied), pending empty, state=BLANK with the counter loaded.
- State machine has 2 states: BLANK and ON.
- BLANK:
  - Enable=3'b111.
  - BinValue is registered to the active value of the current digit on entry, so the decoder settles before the digit is lit.
  - Stays BLANK_CYCLES cycles, then goes to ON.
  - If BLANK_CYCLES=0, BLANK lasts 1 cycle. This cycle is mandatory to load BinValue.
- ON:
  - Enable = the encoding for the current digit, or 3'b111 if that digit's active mask bit is 1.
  - Stays exactly DWELL cycles, then goes to BLANK with the index advanced 0→1→2→0.
- Frame boundary = the transition ON(digit2)→BLANK(digit0). In that cycle:
  - FrameDone=1.
  - If pending is full, active data/mask <= pending and pending is cleared. WrReady rises the next cycle.
- Write handshake:
  - WrReady = !pending_full, registered.
  - On acceptance, WrData/WrBlank are stored in pending.
  - While pending is full, WrValid is ignored and the client must hold it.
- A write accepted in the boundary cycle itself is not taken by that boundary. It goes to pending and is applied at the next boundary (worst-case apply latency is one full frame).
- Frame period = 3*(DWELL + max(BLANK_CYCLES,1)) cycles.
- Counter: single down-counter of width $clog2(max(DWELL,BLANK_CYCLES)+1). Loaded with count-1 on each state entry; the state changes when it reads 0. No wrap beyond this.
- Index value 3 is unreachable. If it is ever decoded, treat it as digit2's boundary and wrap to 0.
- Rst mid-frame: immediate return to the reset values; any pending frame is discarded.

Decomposition:
- Package seg_scan_pkg holds:
  - the state enum {BLANK, ON}
  - NUM_DIGITS=3
  - the enable encodings ENA_OFF=3'b111 and ENA_DIG[0..2]
  - the nibble field offsets for WrData.
- One sub-module: scan_timer (loadable down-counter with a load value input and a zero flag), instantiated once and reloaded on each state entry.

Test Plan (DWELL=4, BLANK_CYCLES=2):
- Reset release, no write → Enable stays 3'b111 for all cycles; FrameDone pulses every 18 cycles; WrReady=1.
- Write WrData=12'h5B1, WrBlank=3'b000 while idle → accepted in 1 cycle; WrReady drops; at the next boundary active=5B1 and WrReady returns to 1; the following frame shows BinValue 1/B/5 with Enable 110/101/011, each lit 4 cycles and separated by 2 cycles of 111.
- Second write while pending is full (WrValid held) → WrReady=0 until the boundary; the write is accepted the cycle after WrReady rises; the displayed frame changes only at the boundary after that.
- Write asserted exactly in the FrameDone cycle with pending empty → captured in pending, not displayed this frame, displayed from the next boundary.
- WrBlank=3'b010 with data 12'h123 → digit1 slot keeps Enable=3'b111 for all 4 ON cycles; digits 0 and 2 light normally; the frame period is unchanged.
- Rst pulse during ON(digit1) → Enable=3'b111, WrReady=1 and FrameDone=0 within the same cycle; the display stays dark until a new write is applied.
